// File: rtl/wb_sram16_ctrl_pkg.sv
// Shared definitions for the Wishbone classic to 16-bit asynchronous SRAM bridge.
// Holds the controller state encoding, the half-word select constants and the byte-enable helper.
package wb_sram16_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_HI     = 3'd1,
        RD_LO     = 3'd2,
        WR_HI     = 3'd3,
        WR_HI_REL = 3'd4,
        WR_LO     = 3'd5,
        WR_LO_REL = 3'd6,
        ACK       = 3'd7
    } state_t;

    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    // Active-low {ub_n, lb_n} for one half of a big-endian 32-bit byte select.
    function automatic logic [1:0] half_be_n(input logic [3:0] sel, input logic half);
        return (half == HALF_HI) ? ~sel[3:2] : ~sel[1:0];
    endfunction

endpackage

// File: rtl/wb_sram16_ctrl.sv
// Wishbone classic slave splitting each 32-bit access into two half-word cycles on a
// 16-bit asynchronous SRAM; big-endian, every output registered.
module wb_sram16_ctrl
    import wb_sram16_ctrl_pkg::*;
#(
    parameter int adr_width = 18,
    parameter int latency   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [adr_width-1:0] sram_adr,
    inout  wire  [15:0]          sram_dat,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n
);

    localparam logic [3:0] CNT_LOAD = 4'(latency - 1);

    state_t               state;
    logic [3:0]           cnt;
    logic [adr_width-2:0] word_adr;
    logic [15:0]          dat_lo;
    logic [1:0]           sel_lo;
    logic [15:0]          dout;
    logic                 drive;
    logic                 start;

    wire unused_adr = &{1'b0, wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};

    assign sram_dat = drive ? dout : 16'bz;
    assign start    = wb_stb_i & wb_cyc_i & ~wb_ack_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            sram_adr  <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            drive     <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_adr <= wb_adr_i[adr_width:2];
                        dat_lo   <= wb_dat_i[15:0];
                        sel_lo   <= wb_sel_i[1:0];
                        cnt      <= CNT_LOAD;
                        if (!wb_we_i) begin
                            state     <= RD_HI;
                            sram_adr  <= {wb_adr_i[adr_width:2], HALF_HI};
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end else if (|wb_sel_i[3:2]) begin
                            state                  <= WR_HI;
                            sram_adr               <= {wb_adr_i[adr_width:2], HALF_HI};
                            sram_ce_n              <= 1'b0;
                            sram_we_n              <= 1'b0;
                            {sram_ub_n, sram_lb_n} <= half_be_n(wb_sel_i, HALF_HI);
                            dout                   <= wb_dat_i[31:16];
                            drive                  <= 1'b1;
                        end else if (|wb_sel_i[1:0]) begin
                            state                  <= WR_LO;
                            sram_adr               <= {wb_adr_i[adr_width:2], HALF_LO};
                            sram_ce_n              <= 1'b0;
                            sram_we_n              <= 1'b0;
                            {sram_ub_n, sram_lb_n} <= half_be_n(wb_sel_i, HALF_LO);
                            dout                   <= wb_dat_i[15:0];
                            drive                  <= 1'b1;
                        end else begin
                            // Nothing selected: acknowledge without touching the SRAM.
                            state    <= ACK;
                            wb_ack_o <= 1'b1;
                        end
                    end
                end
                RD_HI: begin
                    if (cnt == 4'd0) begin
                        wb_dat_o[31:16] <= sram_dat;
                        state           <= RD_LO;
                        sram_adr        <= {word_adr, HALF_LO};
                        cnt             <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_LO: begin
                    if (cnt == 4'd0) begin
                        wb_dat_o[15:0] <= sram_dat;
                        state          <= ACK;
                        wb_ack_o       <= 1'b1;
                        sram_ce_n      <= 1'b1;
                        sram_oe_n      <= 1'b1;
                        sram_ub_n      <= 1'b1;
                        sram_lb_n      <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HI, WR_LO: begin
                    if (cnt == 4'd0) begin
                        // Release we_n one cycle early so address and data see a hold time.
                        state     <= (state == WR_HI) ? WR_HI_REL : WR_LO_REL;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HI_REL: begin
                    if (|sel_lo) begin
                        state                  <= WR_LO;
                        sram_adr               <= {word_adr, HALF_LO};
                        sram_we_n              <= 1'b0;
                        {sram_ub_n, sram_lb_n} <= half_be_n({2'b00, sel_lo}, HALF_LO);
                        dout                   <= dat_lo;
                        cnt                    <= CNT_LOAD;
                    end else begin
                        state     <= ACK;
                        wb_ack_o  <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        drive     <= 1'b0;
                    end
                end
                WR_LO_REL: begin
                    state     <= ACK;
                    wb_ack_o  <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    drive     <= 1'b0;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram16_ctrl.sv
// Bench for wb_sram16_ctrl: three instances (latency 2, 1, 3), each on its own SRAM model,
// driven one at a time; a monitor pops expected responses from a queue on every ack.
module tb_wb_sram16_ctrl;

    localparam int AW = 8;

    typedef struct {
        int          dut;
        bit          is_rd;
        logic [31:0] dat;
        int          start;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clr;
    logic        stb, cyc, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    int          act;

    wire [2:0]          ack_v, ce_n_v, oe_n_v, we_n_v, ub_n_v, lb_n_v;
    wire [2:0][31:0]    dat_o_v;
    wire [2:0][AW-1:0]  adr_v;

    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ce_lo, oe_lo, we_lo, ub_wr, lb_wr;
    exp_t exp_q[$];
    logic [31:0] shadow [3][2**(AW-1)];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        wire  [15:0] sram_dat;
        logic [15:0] mem [2**AW];
        logic        stb_g;

        assign stb_g = stb && (act == g);

        wb_sram16_ctrl #(.adr_width(AW), .latency(LAT)) dut (
            .clk      (clk),
            .reset    (reset),
            .wb_stb_i (stb_g),
            .wb_cyc_i (cyc),
            .wb_we_i  (we),
            .wb_adr_i (adr),
            .wb_sel_i (sel),
            .wb_dat_i (wdat),
            .wb_dat_o (dat_o_v[g]),
            .wb_ack_o (ack_v[g]),
            .sram_adr (adr_v[g]),
            .sram_dat (sram_dat),
            .sram_ce_n(ce_n_v[g]),
            .sram_oe_n(oe_n_v[g]),
            .sram_we_n(we_n_v[g]),
            .sram_ub_n(ub_n_v[g]),
            .sram_lb_n(lb_n_v[g])
        );

        // Asynchronous SRAM model: combinational read, byte-lane write while we_n is low.
        assign sram_dat = (!ce_n_v[g] && !oe_n_v[g] && we_n_v[g]) ? mem[adr_v[g]] : 16'bz;

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
            end else if (!ce_n_v[g] && !we_n_v[g]) begin
                if (!ub_n_v[g]) mem[adr_v[g]][15:8] <= sram_dat[15:8];
                if (!lb_n_v[g]) mem[adr_v[g]][7:0]  <= sram_dat[7:0];
            end
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    // Monitor: scores every ack against the oldest expectation and tallies strobe activity.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!ce_n_v[act]) ce_lo++;
            if (!oe_n_v[act]) oe_lo++;
            if (!we_n_v[act]) we_lo++;
            if (!we_n_v[act] && !ub_n_v[act]) ub_wr++;
            if (!we_n_v[act] && !lb_n_v[act]) lb_wr++;
            for (int g = 0; g < 3; g++) begin
                if (ack_v[g]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ack: dut %0d acked with nothing outstanding", g);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_dut", g, e.dut);
                        check("ack_latency", cyc_cnt - e.start, e.lat);
                        if (e.is_rd) check("read_data", dat_o_v[g], e.dat);
                    end
                end
            end
        end
    end

    task automatic clear_tally();
        ce_lo = 0; oe_lo = 0; we_lo = 0; ub_wr = 0; lb_wr = 0;
    endtask

    task automatic wait_ack(input int d, output bit got);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = ack_v[d];
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: dut %0d no ack within 100 cycles", d);
        end
    endtask

    // One Wishbone access; expected response comes from the word-level shadow memory.
    task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] dt, input bit hold);
        exp_t e;
        int   idx, L, nh;
        bit   got;
        @(negedge clk);
        idx = int'(a[AW:2]);
        L   = lat_of(d);
        e.dut = d;
        e.is_rd = !w;
        e.dat = shadow[d][idx];
        e.start = cyc_cnt;
        if (!w) begin
            e.lat = 1 + 2 * L;
        end else begin
            nh = int'(|s[3:2]) + int'(|s[1:0]);
            e.lat = 1 + nh * (L + 1);
            for (int b = 0; b < 4; b++)
                if (s[b]) shadow[d][idx][8*b +: 8] = dt[8*b +: 8];
        end
        exp_q.push_back(e);
        clear_tally();
        act = d; we = w; adr = a; sel = s; wdat = dt; stb = 1'b1; cyc = 1'b1;
        wait_ack(d, got);
        if (got && hold) begin
            // stb still high in the IDLE cycle after ack starts a fresh access.
            e.start = cyc_cnt + 1;
            exp_q.push_back(e);
            wait_ack(d, got);
        end
        stb = 1'b0;
        cyc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          d;
        bit          w;

        reset = 1'b1; mem_clr = 1'b1; act = 0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; sel = '0; wdat = '0;
        for (int d0 = 0; d0 < 3; d0++)
            for (int i = 0; i < 2**(AW-1); i++) shadow[d0][i] = '0;
        clear_tally();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_ctrl", {ack_v[g], ce_n_v[g], oe_n_v[g], we_n_v[g], ub_n_v[g], lb_n_v[g]}, 32'b011111);
            check("reset_dat_o", dat_o_v[g], 32'h0);
            check("reset_adr", adr_v[g], 32'h0);
        end
        reset = 1'b0; mem_clr = 1'b0;

        do_txn(0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        check("mem_hi_half", g_dut[0].mem[8], 32'h0000_DEAD);
        check("mem_lo_half", g_dut[0].mem[9], 32'h0000_BEEF);

        do_txn(0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0);
        check("read_we_low_cycles", we_lo, 0);
        check("read_oe_low_cycles", oe_lo, 4);

        do_txn(0, 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, 1'b0);
        check("lo_write_ub_cycles", ub_wr, 0);
        check("lo_write_lb_cycles", lb_wr, 2);
        check("lo_write_ce_cycles", ce_lo, 3);

        do_txn(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0);

        do_txn(0, 1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        check("sel0_ce_cycles", ce_lo, 0);
        check("sel0_mem_hi", g_dut[0].mem[8], 32'h0000_DEAD);
        check("sel0_mem_lo", g_dut[0].mem[9], 32'h0000_BEAA);

        // Reset lands at the end of cycle 2 of a full-word write.
        @(negedge clk);
        act = 0; we = 1'b1; adr = 32'h0000_0020; sel = 4'b1111; wdat = 32'h1234_5678;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ctrl", {ack_v[0], ce_n_v[0], oe_n_v[0], we_n_v[0], ub_n_v[0], lb_n_v[0]}, 32'b011111);
        check("midreset_adr", adr_v[0], 32'h0);
        reset = 1'b0; stb = 1'b0; cyc = 1'b0;
        repeat (6) @(negedge clk);

        do_txn(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0);

        do_txn(1, 1'b1, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 1'b0);
        do_txn(1, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 1'b1);

        for (int i = 0; i < 50; i++) begin
            d = 1 + int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            a = $urandom;
            a[AW:2] = (AW-1)'($urandom_range(0, 15));
            do_txn(d, w, a, s, $urandom, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("pending_acks", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
